// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected layer sequencer.
//   fc_seq_state_t : sequencer FSM state encoding
//   FC_NCH         : channel count of the fc datapath
//   FC_LENGTH      : default elements per channel
//   FC_WWORDS      : weight words per load (weights plus one bias word)
//   FC_RESULTS     : serial results produced per pass
package fc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StFeed,
    StDrain,
    StWaitDone
  } fc_seq_state_t;

  localparam int unsigned FC_NCH     = 4;
  localparam int unsigned FC_LENGTH  = 64;
  localparam int unsigned FC_WWORDS  = FC_NCH * FC_LENGTH + 1;
  localparam int unsigned FC_RESULTS = FC_NCH * FC_LENGTH;

endpackage

// File: rtl/fc_stagger.sv
// Per-channel delay line: channel k is delayed k cycles relative to channel 0.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : beat strobe shared by all channels
//   in_data    : NCH packed lanes, lane 0 in the LSBs
//   out_valid  : per-channel delayed strobe
//   out_data   : per-channel delayed data, zero when the lane carries no beat
module fc_stagger #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NCH        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [NCH*DATA_WIDTH-1:0] in_data,
  output logic [NCH-1:0]            out_valid,
  output logic [NCH*DATA_WIDTH-1:0] out_data
);

  // Lane 0 has no delay; gate it so idle lanes read as zero.
  assign out_valid[0]              = in_valid;
  assign out_data[DATA_WIDTH-1:0]  = in_valid ? in_data[DATA_WIDTH-1:0] : '0;

  for (genvar k = 1; k < NCH; k++) begin : g_lane
    logic [k-1:0]                 vld_q;
    logic [k-1:0][DATA_WIDTH-1:0] dat_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        dat_q[0] <= in_valid ? in_data[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s < k; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign out_valid[k]                          = vld_q[k-1];
    assign out_data[k*DATA_WIDTH +: DATA_WIDTH]  = dat_q[k-1];
  end

endmodule

// File: rtl/fc_sequencer.sv
// Sequences one fully-connected layer pass: weight/bias load, staggered
// feature streaming, tagging of the serial product stream, completion report.
// Optional build macro FC_SEQ_ACC_EN adds a per-channel result accumulator.
//   clk, rst          : clock, asynchronous active-high reset
//   start, reload_w   : pass request (idle only) and weight-reload select
//   w_rd_*            : weight memory read port, 1-cycle latency; last word is bias
//   fc_weight/bias/.. : weight/bias beats to the datapath
//   f_rd_*            : feature buffer read port, 4 packed channels, 1-cycle latency
//   fc_data/fc_ivalid : staggered channel data and per-channel valid
//   fc_result/fc_done : serial result stream and completion pulse from datapath
//   res_*             : registered, tagged result stream
//   busy, done, err   : status; err is sticky until rst or an accepted start
//   acc_valid/acc_data: (FC_SEQ_ACC_EN only) per-channel signed result sum
module fc_sequencer
  import fc_pkg::*;
#(
  parameter int unsigned LENGTH_FC    = FC_LENGTH,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned FILTERBATCH  = FC_NCH,
  parameter int unsigned DONE_TIMEOUT = 8,
  parameter int unsigned WADDR_W      = $clog2(FILTERBATCH*LENGTH_FC+1),
  parameter int unsigned FADDR_W      = $clog2(LENGTH_FC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      reload_w,
  output logic                      w_rd_en,
  output logic [WADDR_W-1:0]        w_rd_addr,
  input  logic [DATA_WIDTH-1:0]     w_rd_data,
  output logic [DATA_WIDTH-1:0]     fc_weight,
  output logic [DATA_WIDTH-1:0]     fc_bias,
  output logic                      fc_weight_valid,
  output logic                      f_rd_en,
  output logic [FADDR_W-1:0]        f_rd_addr,
  input  logic [DATA_WIDTH*4-1:0]   f_rd_data,
  output logic [DATA_WIDTH*4-1:0]   fc_data,
  output logic [FC_NCH-1:0]         fc_ivalid,
  input  logic [2*DATA_WIDTH-1:0]   fc_result,
  input  logic                      fc_done,
  output logic                      res_valid,
  output logic [2*DATA_WIDTH-1:0]   res_data,
  output logic [1:0]                res_ch,
  output logic [FADDR_W-1:0]        res_idx,
  output logic                      busy,
  output logic                      done,
  output logic                      err
`ifdef FC_SEQ_ACC_EN
  ,
  output logic                                    acc_valid,
  output logic signed [2*DATA_WIDTH+FADDR_W-1:0]  acc_data
`endif
);

  localparam int unsigned NWORDS   = FILTERBATCH * LENGTH_FC + 1;
  localparam int unsigned NRESULTS = FILTERBATCH * LENGTH_FC;
  localparam int unsigned CNT_W    = WADDR_W + 1;

  localparam logic [CNT_W-1:0] LAST_WADDR   = CNT_W'(NWORDS - 1);
  localparam logic [CNT_W-1:0] LAST_WBEAT   = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] FEED_BEATS   = CNT_W'(LENGTH_FC);
  localparam logic [CNT_W-1:0] LAST_RESULT  = CNT_W'(NRESULTS - 1);
  localparam logic [CNT_W-1:0] LAST_TIMEOUT = CNT_W'(DONE_TIMEOUT - 1);

  fc_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic w_loaded_q, w_loaded_d;
  logic err_q, err_d;
  logic done_q, done_d;

  logic wv_q, bias_q, fv_q;
  logic res_valid_q;
  logic [2*DATA_WIDTH-1:0] res_data_q;
  logic [1:0] res_ch_q;
  logic [FADDR_W-1:0] res_idx_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      w_loaded_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_loaded_q <= w_loaded_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. cnt_q is the beat/cycle counter of the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    w_loaded_d = w_loaded_q;
    err_d      = err_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          err_d = 1'b0;
          if (reload_w && !w_loaded_q) begin
            state_d = StLoadW;
          end else if (reload_w) begin
            // Datapath weight counter cannot rewind without reset: flag and reuse.
            err_d   = 1'b1;
            state_d = StFeed;
          end else if (!w_loaded_q) begin
            err_d = 1'b1;
          end else begin
            state_d = StFeed;
          end
        end
      end
      StLoadW: begin
        // Stays one cycle past the last read so the bias beat lands in LOAD_W.
        if (cnt_q == LAST_WBEAT) begin
          state_d    = StFeed;
          cnt_d      = '0;
          w_loaded_d = 1'b1;
        end
      end
      StFeed: begin
        if (cnt_q == FEED_BEATS) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (cnt_q == LAST_RESULT) begin
          state_d = StWaitDone;
          cnt_d   = '0;
        end
      end
      StWaitDone: begin
        if (fc_done) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (cnt_q == LAST_TIMEOUT) begin
          state_d = StIdle;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fc_done && (state_q != StWaitDone)) err_d = 1'b1;
  end

  // Outputs decoded from state.
  always_comb begin
    w_rd_en         = 1'b0;
    w_rd_addr       = '0;
    f_rd_en         = 1'b0;
    f_rd_addr       = '0;
    busy            = (state_q != StIdle);
    fc_weight_valid = wv_q;
    fc_weight       = wv_q ? w_rd_data : '0;
    fc_bias         = bias_q ? w_rd_data : '0;
    if (state_q == StLoadW && cnt_q <= LAST_WADDR) begin
      w_rd_en   = 1'b1;
      w_rd_addr = cnt_q[WADDR_W-1:0];
    end
    if (state_q == StFeed && cnt_q < FEED_BEATS) begin
      f_rd_en   = 1'b1;
      f_rd_addr = cnt_q[FADDR_W-1:0];
    end
  end

  // Read-latency alignment and result tagging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wv_q        <= 1'b0;
      bias_q      <= 1'b0;
      fv_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_idx_q   <= '0;
    end else begin
      wv_q        <= w_rd_en;
      bias_q      <= w_rd_en && (cnt_q == LAST_WADDR);
      fv_q        <= f_rd_en;
      res_valid_q <= (state_q == StDrain);
      if (state_q == StDrain) begin
        res_data_q <= fc_result;
        res_ch_q   <= cnt_q[FADDR_W +: 2];
        res_idx_q  <= cnt_q[FADDR_W-1:0];
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign res_idx   = res_idx_q;
  assign done      = done_q;
  assign err       = err_q;

  fc_stagger #(
    .DATA_WIDTH (DATA_WIDTH),
    .NCH        (FC_NCH)
  ) u_stagger (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fv_q),
    .in_data   (f_rd_data),
    .out_valid (fc_ivalid),
    .out_data  (fc_data)
  );

`ifdef FC_SEQ_ACC_EN
  localparam int unsigned ACC_W = 2*DATA_WIDTH + FADDR_W;

  logic signed [ACC_W-1:0] acc_q, acc_sum, acc_data_q;
  logic acc_valid_q;

  assign acc_sum = acc_q + {{FADDR_W{res_data_q[2*DATA_WIDTH-1]}}, res_data_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      acc_data_q  <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      if (res_valid_q) begin
        if (res_idx_q == FADDR_W'(LENGTH_FC - 1)) begin
          acc_data_q  <= acc_sum;
          acc_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;
`endif

endmodule
